seg_scan: RTL and testbench

Time-multiplexed scanner for the board's 8-digit common-anode 7-segment display. It holds a 32-bit value and walks the digits one at a time. For each slot it drives the active-low anode select and the 4-bit nibble that the hex-to-segment decoder consumes, plus the decimal point. The block sits directly upstream of the hex-to-segment decoder, and its nibble output connects straight to that decoder's 4-bit input. New values are double-buffered and committed only at frame boundaries, so a digit never tears mid-frame.

---
 rtl/seg_scan.sv | 114 +++++++++++
 tb/tb_seg_scan.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan: 8-digit multiplexed 7-segment scanner.
// Double-buffered value and decimal points, committed on frame wrap.
module seg_scan #(
  parameter int CLK_DIV = 100000,
  parameter int DEAD    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        load,
  input  logic        lz_en,
  output logic [7:0]  an,
  output logic [3:0]  hex_out,
  output logic        dp_n,
  output logic        frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [31:0]   shadow_data;
  logic [7:0]    shadow_dp;
  logic          pending;
  logic [31:0]   disp_data;
  logic [7:0]    disp_dp;
  logic          disp_lz;
  logic [CW-1:0] div_cnt;
  logic [2:0]    idx;
  logic          run;

  logic [CW-1:0] div_nx;
  logic [2:0]    idx_nx;
  logic          commit;
  logic [31:0]   dd_nx;
  logic [7:0]    dp_nx;
  logic          lz_nx;
  logic [4:0]    shamt;
  logic          blank;
  logic          dead;
  logic [7:0]    an_nx;
  logic          dpn_nx;

  // run holds slot 0 / count 0 on the first edge after reset release
  always_comb begin
    div_nx = '0;
    idx_nx = '0;
    commit = 1'b0;
    dd_nx  = disp_data;
    dp_nx  = disp_dp;
    lz_nx  = disp_lz;
    if (run) begin
      if (div_cnt == LAST) begin
        idx_nx = idx + 3'd1;
        commit = (idx == 3'd7);
      end else begin
        div_nx = div_cnt + CW'(1);
        idx_nx = idx;
      end
    end
    if (commit && pending) begin
      dd_nx = shadow_data;
      dp_nx = shadow_dp;
      lz_nx = lz_en;
    end
    shamt  = {idx_nx, 2'b00};
    blank  = lz_nx && (idx_nx != 3'd0) && ((dd_nx >> shamt) == 32'd0);
    dead   = int'(div_nx) < DEAD;
    an_nx  = 8'hFF;
    dpn_nx = 1'b1;
    if (!dead && !blank) begin
      an_nx  = ~(8'b1 << idx_nx);
      dpn_nx = ~dp_nx[idx_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b0;
      disp_data   <= '0;
      disp_dp     <= '0;
      disp_lz     <= 1'b0;
      div_cnt     <= '0;
      idx         <= '0;
      run         <= 1'b0;
      an          <= 8'hFF;
      hex_out     <= 4'h0;
      dp_n        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      run        <= 1'b1;
      div_cnt    <= div_nx;
      idx        <= idx_nx;
      disp_data  <= dd_nx;
      disp_dp    <= dp_nx;
      disp_lz    <= lz_nx;
      an         <= an_nx;
      hex_out    <= dd_nx[shamt +: 4];
      dp_n       <= dpn_nx;
      frame_done <= commit;
      // a load on the commit edge lands after the old shadow is taken
      if (load) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
        pending     <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed steps with a per-cycle expected-output queue.
// Frame-level display model, CLK_DIV=4, DEAD=1.
module tb_seg_scan;

  localparam int CD = 4;
  localparam int DT = 1;
  localparam int FR = 8 * CD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic [7:0]  an;
  logic [3:0]  hex_out;
  logic        dp_n;
  logic        frame_done;

  seg_scan #(.CLK_DIV(CD), .DEAD(DT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .dp_in(dp_in),
    .load(load),
    .lz_en(lz_en),
    .an(an),
    .hex_out(hex_out),
    .dp_n(dp_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          t     = -1;
  string       tag   = "reset";
  logic [31:0] cur_d = '0;
  logic [7:0]  cur_dp = '0;
  logic        cur_lz = 1'b0;
  logic [31:0] nxt_d = '0;
  logic [7:0]  nxt_dp = '0;
  logic        pend = 1'b0;
  logic [13:0] sb[$];

  task automatic tick();
    logic [13:0] e;
    logic [13:0] got;
    logic [7:0]  ea;
    logic        edp;
    logic        fd;
    int          slot;
    int          c;
    int          hi;
    @(posedge clk);
    if (!rst_n) begin
      t      = -1;
      cur_d  = '0;
      cur_dp = '0;
      cur_lz = 1'b0;
      pend   = 1'b0;
      e      = {8'hFF, 4'h0, 1'b1, 1'b0};
    end else begin
      t++;
      fd = 1'b0;
      if (t > 0 && t % FR == 0) begin
        fd = 1'b1;
        if (pend) begin
          cur_d  = nxt_d;
          cur_dp = nxt_dp;
          cur_lz = lz_en;
          pend   = 1'b0;
        end
      end
      if (load) begin
        nxt_d  = data_in;
        nxt_dp = dp_in;
        pend   = 1'b1;
      end
      slot = (t / CD) % 8;
      c    = t % CD;
      hi   = 0;
      for (int k = 0; k < 8; k++)
        if (cur_d[4*k +: 4] != 4'h0) hi = k;
      ea  = 8'hFF;
      edp = 1'b1;
      if (c >= DT && !(cur_lz && slot > hi)) begin
        ea  = ~(8'b1 << slot);
        edp = ~cur_dp[slot];
      end
      e = {ea, cur_d[4*slot +: 4], edp, fd};
    end
    sb.push_back(e);
    #1;
    got = {an, hex_out, dp_n, frame_done};
    e   = sb.pop_front();
    total++;
    assert (got === e) else begin
      bad++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, e);
    end
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] p);
    data_in = d;
    dp_in   = p;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    data_in = '0;
    dp_in   = '0;
    load    = 1'b0;
    lz_en   = 1'b0;
    repeat (3) tick();

    tag   = "scan";
    rst_n = 1'b1;
    repeat (10) tick();

    tag = "load_1234abcd";
    do_load(32'h1234ABCD, 8'h01);
    repeat (60) tick();

    tag   = "lz_f0";
    lz_en = 1'b1;
    do_load(32'h0000_00F0, 8'h00);
    repeat (70) tick();

    tag = "lz_zero";
    do_load(32'h0, 8'hFF);
    repeat (70) tick();

    tag   = "double";
    lz_en = 1'b0;
    do_load(32'h1111_1111, 8'h00);
    repeat (3) tick();
    do_load(32'h2222_2222, 8'h80);
    while (t % FR != FR - 1) tick();

    tag = "collide";
    do_load(32'h3333_3333, 8'h10);
    repeat (70) tick();

    tag = "mid_reset";
    do_load(32'h4444_4444, 8'h0F);
    repeat (5) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (80) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
